mem2axi: RTL and testbench
==========================

# mem2axi

Single-outstanding bridge from the core-style SRAM request port to a single-beat AXI4 initiator port.
- It lets a simple `cs`/`we`/`addr`/`byte` requester (test engines, boot loaders, debug access) reach `marb` and the memory/peripheral fabric as an ordinary AXI master.
- Requests are ordered and not pipelined.
- AXI error responses are returned on a `bad` code matching the core's `imem_bad`/`dmem_bad` encoding.

## Interface
Parameters:
- `ID_W`, 10: AXI ID width.
- `ID_VAL`, 0: constant ID driven on `awid`/`arid`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk`, in, 1: clock.
  - `rst`, in, 1: asynchronous active-high reset.
- Request port:
  - `cs`, in, 1: request strobe.
  - `we`, in, 1: 1 = write.
  - `addr`, in, 32: byte address; bits [1:0] are ignored (word aligned).
  - `byte`, in, 4: write byte strobes.
  - `di`, in, 32: write data.
  - `do`, out, 32: read data.
  - `bad`, out, 2: response code of the last completed access (00 OKAY, 10 SLVERR, 11 DECERR).
  - `busy`, out, 1: access in progress.
  - `wr_err`, out, 1: one-cycle pulse on an errored posted-write B response (posting build only; tied 0 otherwise).
- AXI write address: `awid`[ID_W], `awaddr`[32], `awlen`[8], `awsize`[3], `awburst`[2], `awvalid`, `awready`.
- AXI write data: `wdata`[32], `wstrb`[4], `wlast`, `wvalid`, `wready`.
- AXI write response: `bid`[ID_W], `bresp`[2], `bvalid`, `bready`.
- AXI read address: `arid`[ID_W], `araddr`[32], `arlen`[8], `arsize`[3], `arburst`[2], `arvalid`, `arready`.
- AXI read data: `rid`[ID_W], `rdata`[32], `rresp`[2], `rlast`, `rvalid`, `rready`.

## Operation
Acceptance and capture:
- A request is accepted at any rising edge with `cs`=1 and `busy`=0.
- `addr`, `we`, `byte` and `di` are captured into registers; requester inputs are not used after acceptance.
- Constant AXI fields: `awlen`/`arlen`=0, `awsize`/`arsize`=3'b010, `awburst`/`arburst`=2'b01 (INCR), `wlast`=1.
- `awaddr`/`araddr` carry the captured address with [1:0] forced to 00.

FSM:
- IDLE: accept → RD_A (read) or WR_A (write).
- RD_A: `arvalid`=1 until `arready`; then → RD_D.
- RD_D: `rready`=1; on `rvalid`, capture `rdata`→`do` and `rresp`→`bad`; → IDLE.
- WR_A: `awvalid` and `wvalid` are driven together from entry. Each drops independently on its own handshake; both handshakes may occur in the same cycle. When both are done → WR_B.
- WR_B: `bready`=1; on `bvalid`, `bresp`→`bad`; → IDLE. `do` holds its previous value.

Rules and boundary conditions:
- `busy` = (state != IDLE), registered.
- No valid is ever withdrawn before its handshake.
- `rid`/`bid` are ignored; `rlast` is ignored (single beat).
- Reset asserted mid-transaction: all valids and readies drop immediately, state → IDLE, no response is reported. The fabric must also be reset.
- Reset values: `awvalid`/`wvalid`/`arvalid`/`bready`/`rready`=0, `busy`=0, `do`=0, `bad`=0, `wr_err`=0.

## Timing
- Acceptance at edge N; `busy`=1 from cycle N+1.
- With zero-wait fabric, `arvalid`/`awvalid`/`wvalid` are high in cycle N+1.
- Minimum read: handshake at N+1, `rvalid` at N+2 → `busy`=0 and `do`/`bad` valid at N+3.
- Minimum write: AW/W at N+1, B at N+2 → `busy`=0 at N+3.
- Each AXI stall cycle adds one cycle.
- `do`/`bad` are valid from the first `busy`=0 cycle and hold until the next completion.
- The earliest next acceptance is the first `busy`=0 cycle.

## Configuration
`MEM2AXI_WPOST_EN`, defined (posted writes):
- WR_A exits directly to IDLE once both AW and W have handshaken, and `bad`=00 is reported for the write.
- A `b_pend` flag tracks the outstanding B; `bready`=1 while `b_pend`.
- B response: clears `b_pend`; non-OKAY `bresp` pulses `wr_err` for one cycle.
- A request accepted while `b_pend`=1 is captured, but its AR/AW is not issued until `b_pend` clears (ordering).
- Reset clears `b_pend`.

`MEM2AXI_WPOST_EN` undefined:
- The WR_B state is used as described above.
- `wr_err` is tied to 0.

## Structure
- Package `axi_pkg` holds:
  - resp constants: OKAY, EXOKAY, SLVERR, DECERR;
  - burst encodings;
  - size encoding `AXI_SIZE_4B`;
  - the FSM state enum (IDLE, RD_A, RD_D, WR_A, WR_B).
- Single module; no sub-module is warranted.

## Test plan
- Reset → all outputs at reset values; `cs`=1 with `we`=0 while `rst`=1 produces no `arvalid`.
- Read at 0x0001_0004, `arready` low for 2 cycles, `rdata`=0xDEAD_BEEF after 3 cycles → `araddr`=0x0001_0004, `do`=0xDEAD_BEEF, `bad`=00, `busy` high exactly 1+2+3 cycles.
- Write at 0x0000_0010, `byte`=4'b0011, `di`=0x1234_5678:
  - fabric accepts W two cycles before AW → `wstrb`=0011 and `wdata` correct;
  - B only after both handshakes.
- Read at 0x0000_0008 with `rresp`=SLVERR → `bad`=2'b10, `do`=`rdata`; next OKAY access → `bad`=00.
- Posting build:
  - write then immediate read, `bvalid` delayed 5 cycles with DECERR → no `arvalid` before B handshake;
  - `wr_err` pulses once;
  - read completes OKAY.
- `rst` asserted in RD_D → `rready`/`busy` drop the same cycle; after release, a fresh read completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// axi_pkg: AXI4 response/burst/size encodings and the mem2axi FSM state type.
package axi_pkg;

   // AXI response codes (also the encoding of the bridge's `bad` output)
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // AXI burst encodings
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   // Size encoding for a 32-bit beat, and the single-beat length
   localparam logic [2:0] AXI_SIZE_4B = 3'b010;
   localparam logic [7:0] AXI_LEN_1   = 8'd0;

   // Bridge FSM states
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD_A = 3'd1,
      RD_D = 3'd2,
      WR_A = 3'd3,
      WR_B = 3'd4
   } state_t;

   // Anything other than OKAY is reported as a write error
   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp != RESP_OKAY);
   endfunction

endpackage

// File: rtl/mem2axi.sv
// mem2axi: single-outstanding bridge from the cs/we/addr/byte_en request port to a
// single-beat AXI4 initiator. Define MEM2AXI_WPOST_EN to post writes: the bridge
// returns to IDLE after AW/W, tracks the B response in the background and flags
// an errored B on wr_err; later AR/AW issue waits for that B (ordering).
// The byte strobe and read data ports are named byte_en/dout because `byte` and
// `do` are reserved words in SystemVerilog.
module mem2axi
   import axi_pkg::*;
#(
   parameter int ID_W   = 10,
   parameter int ID_VAL = 0
) (
   input  logic            clk,
   input  logic            rst,
   // request port
   input  logic            cs,
   input  logic            we,
   input  logic [31:0]     addr,
   input  logic [3:0]      byte_en,
   input  logic [31:0]     di,
   output logic [31:0]     dout,
   output logic [1:0]      bad,
   output logic            busy,
   output logic            wr_err,
   // AXI write address
   output logic [ID_W-1:0] awid,
   output logic [31:0]     awaddr,
   output logic [7:0]      awlen,
   output logic [2:0]      awsize,
   output logic [1:0]      awburst,
   output logic            awvalid,
   input  logic            awready,
   // AXI write data
   output logic [31:0]     wdata,
   output logic [3:0]      wstrb,
   output logic            wlast,
   output logic            wvalid,
   input  logic            wready,
   // AXI write response
   input  logic [ID_W-1:0] bid,
   input  logic [1:0]      bresp,
   input  logic            bvalid,
   output logic            bready,
   // AXI read address
   output logic [ID_W-1:0] arid,
   output logic [31:0]     araddr,
   output logic [7:0]      arlen,
   output logic [2:0]      arsize,
   output logic [1:0]      arburst,
   output logic            arvalid,
   input  logic            arready,
   // AXI read data
   input  logic [ID_W-1:0] rid,
   input  logic [31:0]     rdata,
   input  logic [1:0]      rresp,
   input  logic            rlast,
   input  logic            rvalid,
   output logic            rready
);

   localparam logic [ID_W-1:0] ID_CONST = ID_W'(ID_VAL);

   state_t      state_r, state_nx;
   logic [29:0] addr_r;
   logic [3:0]  be_r;
   logic [31:0] di_r;
   logic        issued_r, issued_nx;
   logic        arvalid_r, arvalid_nx;
   logic        awvalid_r, awvalid_nx;
   logic        wvalid_r, wvalid_nx;
   logic        rready_r, rready_nx;
   logic        bready_r, bready_nx;
   logic [31:0] dout_r, dout_nx;
   logic [1:0]  bad_r, bad_nx;
   logic        busy_r, busy_nx;
   logic        wr_err_r, wr_err_nx;
   logic        b_pend_r, b_pend_nx;
   logic        accept_s;
   logic        go_s;
   logic        aw_left_s;
   logic        w_left_s;
   logic        unused_s;

   // IDs, beat routing and the low address bits play no part in a single-beat,
   // single-outstanding, word-aligned bridge.
   assign unused_s = ^{bid, rid, rlast, addr[1:0]};

   // Next-state and next-output logic; every output is registered from these values.
   always_comb begin
      state_nx   = state_r;
      issued_nx  = issued_r;
      arvalid_nx = arvalid_r;
      awvalid_nx = awvalid_r;
      wvalid_nx  = wvalid_r;
      rready_nx  = rready_r;
      bready_nx  = bready_r;
      dout_nx    = dout_r;
      bad_nx     = bad_r;
      wr_err_nx  = 1'b0;
      b_pend_nx  = b_pend_r;
      accept_s   = 1'b0;
      aw_left_s  = awvalid_r & ~awready;
      w_left_s   = wvalid_r & ~wready;

`ifdef MEM2AXI_WPOST_EN
      // Background B response for a posted write (bready mirrors b_pend).
      if (b_pend_r && bvalid) begin
         b_pend_nx = 1'b0;
         bready_nx = 1'b0;
         wr_err_nx = resp_is_err(bresp);
      end else begin
         b_pend_nx = b_pend_r;
      end
`endif

      // A new AR/AW may be issued only once no posted B is outstanding.
      go_s = ~b_pend_nx;

      case (state_r)
         IDLE: begin
            if (cs) begin
               accept_s  = 1'b1;
               issued_nx = go_s;
               if (we) begin
                  state_nx   = WR_A;
                  awvalid_nx = go_s;
                  wvalid_nx  = go_s;
               end else begin
                  state_nx   = RD_A;
                  arvalid_nx = go_s;
               end
            end else begin
               state_nx = IDLE;
            end
         end

         RD_A: begin
            if (!issued_r) begin
               // Captured while a posted B was pending: issue once it clears.
               issued_nx  = go_s;
               arvalid_nx = go_s;
            end else if (arready) begin
               issued_nx  = 1'b0;
               arvalid_nx = 1'b0;
               rready_nx  = 1'b1;
               state_nx   = RD_D;
            end else begin
               arvalid_nx = 1'b1;
            end
         end

         RD_D: begin
            if (rvalid) begin
               dout_nx   = rdata;
               bad_nx    = rresp;
               rready_nx = 1'b0;
               state_nx  = IDLE;
            end else begin
               rready_nx = 1'b1;
            end
         end

         WR_A: begin
            if (!issued_r) begin
               issued_nx  = go_s;
               awvalid_nx = go_s;
               wvalid_nx  = go_s;
            end else begin
               // AW and W each drop on their own handshake.
               awvalid_nx = aw_left_s;
               wvalid_nx  = w_left_s;
               if (!aw_left_s && !w_left_s) begin
                  issued_nx = 1'b0;
`ifdef MEM2AXI_WPOST_EN
                  state_nx  = IDLE;
                  bad_nx    = RESP_OKAY;
                  b_pend_nx = 1'b1;
                  bready_nx = 1'b1;
`else
                  state_nx  = WR_B;
                  bready_nx = 1'b1;
`endif
               end else begin
                  state_nx = WR_A;
               end
            end
         end

         WR_B: begin
            if (bvalid) begin
               bad_nx    = bresp;
               bready_nx = 1'b0;
               state_nx  = IDLE;
            end else begin
               bready_nx = 1'b1;
            end
         end

         default: begin
            state_nx   = IDLE;
            issued_nx  = 1'b0;
            arvalid_nx = 1'b0;
            awvalid_nx = 1'b0;
            wvalid_nx  = 1'b0;
            rready_nx  = 1'b0;
            bready_nx  = 1'b0;
            b_pend_nx  = 1'b0;
         end
      endcase

      busy_nx = (state_nx != IDLE);
   end

   // State and registered outputs; reset drops every valid/ready immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         issued_r  <= 1'b0;
         arvalid_r <= 1'b0;
         awvalid_r <= 1'b0;
         wvalid_r  <= 1'b0;
         rready_r  <= 1'b0;
         bready_r  <= 1'b0;
         dout_r    <= 32'h0000_0000;
         bad_r     <= RESP_OKAY;
         busy_r    <= 1'b0;
         wr_err_r  <= 1'b0;
         b_pend_r  <= 1'b0;
      end else begin
         state_r   <= state_nx;
         issued_r  <= issued_nx;
         arvalid_r <= arvalid_nx;
         awvalid_r <= awvalid_nx;
         wvalid_r  <= wvalid_nx;
         rready_r  <= rready_nx;
         bready_r  <= bready_nx;
         dout_r    <= dout_nx;
         bad_r     <= bad_nx;
         busy_r    <= busy_nx;
         wr_err_r  <= wr_err_nx;
         b_pend_r  <= b_pend_nx;
      end
   end

   // Request capture at acceptance; requester inputs are ignored afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_r <= 30'd0;
         be_r   <= 4'h0;
         di_r   <= 32'h0000_0000;
      end else if (accept_s) begin
         addr_r <= addr[31:2];
         be_r   <= byte_en;
         di_r   <= di;
      end else begin
         addr_r <= addr_r;
         be_r   <= be_r;
         di_r   <= di_r;
      end
   end

   // Requester side
   assign dout    = dout_r;
   assign bad     = bad_r;
   assign busy    = busy_r;
   assign wr_err  = wr_err_r;

   // AXI write channels
   assign awid    = ID_CONST;
   assign awaddr  = {addr_r, 2'b00};
   assign awlen   = AXI_LEN_1;
   assign awsize  = AXI_SIZE_4B;
   assign awburst = BURST_INCR;
   assign awvalid = awvalid_r;
   assign wdata   = di_r;
   assign wstrb   = be_r;
   assign wlast   = 1'b1;
   assign wvalid  = wvalid_r;
   assign bready  = bready_r;

   // AXI read channels
   assign arid    = ID_CONST;
   assign araddr  = {addr_r, 2'b00};
   assign arlen   = AXI_LEN_1;
   assign arsize  = AXI_SIZE_4B;
   assign arburst = BURST_INCR;
   assign arvalid = arvalid_r;
   assign rready  = rready_r;

endmodule

// File: tb/tb_mem2axi.sv
// tb_mem2axi: table-driven bench for mem2axi with a reactive single-beat AXI
// fabric model, plus hand-written reset and posted-write sequences.
`timescale 1ns/1ps
module tb_mem2axi;
   import axi_pkg::*;

   localparam int ID_W = 10;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            cs, we;
   logic [31:0]     addr, di, dout;
   logic [3:0]      byte_en;
   logic [1:0]      bad;
   logic            busy, wr_err;
   logic [ID_W-1:0] awid, arid, bid, rid;
   logic [31:0]     awaddr, araddr, wdata, rdata;
   logic [7:0]      awlen, arlen;
   logic [2:0]      awsize, arsize;
   logic [1:0]      awburst, arburst, bresp, rresp;
   logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic            arvalid, arready, rlast, rvalid, rready;
   logic [3:0]      wstrb;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem2axi #(.ID_W(ID_W), .ID_VAL(0)) dut (
      .clk(clk), .rst(rst),
      .cs(cs), .we(we), .addr(addr), .byte_en(byte_en), .di(di),
      .dout(dout), .bad(bad), .busy(busy), .wr_err(wr_err),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] di;
      int          ar_stall;
      int          r_lat;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      int          aw_stall;
      int          w_stall;
      int          b_lat;
      logic [1:0]  bresp;
      logic [31:0] exp_do;
      logic [1:0]  exp_bad;
      int          exp_busy;   // busy cycles with a non-posting bridge
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fabric_idle();
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = RESP_OKAY;
      arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = RESP_OKAY;
   endtask

   // One request through a reactive fabric; called at #1 after an edge with busy==0.
   task automatic run_txn(input string tag, input vec_t v);
      int          busy_cnt = 0, ar_seen = 0, aw_seen = 0, w_seen = 0;
      int          ar_cyc = 0, aw_cyc = 0, w_cyc = 0, cyc = 1, exp_busy;
      bit          ar_done = 0, r_done = 0, aw_done = 0, w_done = 0, b_done = 0;
      bit          first_idle = 0, finished = 0, early_b = 0, withdrawn = 0;
      bit          seen_arv = 0, seen_awv = 0, seen_wv = 0;
      logic [31:0] exp_addr, idle_do;
      logic [1:0]  exp_bad, idle_bad;
      exp_addr = v.addr & 32'hFFFF_FFFC;
      exp_busy = v.exp_busy;
      exp_bad  = v.exp_bad;
`ifdef MEM2AXI_WPOST_EN
      if (v.we) begin
         exp_busy = v.exp_busy - v.b_lat;
         exp_bad  = RESP_OKAY;
      end
`endif
      idle_do  = 32'h0;
      idle_bad = 2'b00;
      cs = 1'b1; we = v.we; addr = v.addr; byte_en = v.be; di = v.di;
      @(posedge clk); #1;
      // scramble the requester inputs: the bridge must use its captured copy
      cs = 1'b0; we = ~v.we; addr = ~v.addr; byte_en = ~v.be; di = ~v.di;
      while (!finished && cyc <= 80) begin
         fabric_idle();
         if (!busy && !first_idle) begin
            first_idle = 1; idle_do = dout; idle_bad = bad;
         end
         if (busy) busy_cnt++;
         if (first_idle && (v.we ? b_done : r_done)) begin
            finished = 1;
         end else begin
            if (!v.we) begin
               if (seen_arv && !ar_done && !arvalid) withdrawn = 1;
               if (arvalid && !ar_done) begin
                  seen_arv = 1;
                  if (ar_seen >= v.ar_stall) begin
                     arready = 1'b1; ar_done = 1; ar_cyc = cyc;
                     check({tag, " araddr"}, araddr, exp_addr);
                     check({tag, " ar fields"}, {arid, arlen, arsize, arburst},
                           {10'd0, 8'd0, 3'b010, 2'b01});
                  end
                  ar_seen++;
               end
               if (ar_done && !r_done && (cyc - ar_cyc) >= v.r_lat) begin
                  rvalid = 1'b1; rdata = v.rdata; rresp = v.rresp;
                  if (rready) r_done = 1;
               end
            end else begin
               if (bready && !(aw_done && w_done)) early_b = 1;
               if (seen_awv && !aw_done && !awvalid) withdrawn = 1;
               if (seen_wv && !w_done && !wvalid) withdrawn = 1;
               if (awvalid && !aw_done) begin
                  seen_awv = 1;
                  if (aw_seen >= v.aw_stall) begin
                     awready = 1'b1; aw_done = 1; aw_cyc = cyc;
                     check({tag, " awaddr"}, awaddr, exp_addr);
                     check({tag, " aw fields"}, {awid, awlen, awsize, awburst},
                           {10'd0, 8'd0, 3'b010, 2'b01});
                  end
                  aw_seen++;
               end
               if (wvalid && !w_done) begin
                  seen_wv = 1;
                  if (w_seen >= v.w_stall) begin
                     wready = 1'b1; w_done = 1; w_cyc = cyc;
                     check({tag, " w beat"}, {wdata, wstrb, wlast}, {v.di, v.be, 1'b1});
                  end
                  w_seen++;
               end
               if (aw_done && w_done && !b_done && cyc != aw_cyc && cyc != w_cyc &&
                   (cyc - ((aw_cyc > w_cyc) ? aw_cyc : w_cyc)) >= v.b_lat) begin
                  bvalid = 1'b1; bresp = v.bresp;
                  if (bready) b_done = 1;
               end
            end
            @(posedge clk); #1;
            cyc++;
         end
      end
      fabric_idle();
      check({tag, " completed"}, finished, 1'b1);
      check({tag, " busy cycles"}, busy_cnt, exp_busy);
      check({tag, " do"}, idle_do, v.exp_do);
      check({tag, " bad"}, idle_bad, exp_bad);
      check({tag, " valid withdrawn"}, withdrawn, 1'b0);
      if (v.we) check({tag, " bready before AW+W"}, early_b, 1'b0);
      else      check({tag, " rready after done"}, rready, 1'b0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: still running at 400us, required to finish earlier");
      $fatal(1);
   end

   initial begin
      vec_t rv;
      tbl[0] = '{1'b0, 32'h0001_0004, 4'h0, 32'h0, 2, 3, 32'hDEAD_BEEF, RESP_OKAY,
                 0, 0, 0, RESP_OKAY, 32'hDEAD_BEEF, RESP_OKAY, 6};
      tbl[1] = '{1'b1, 32'h0000_0010, 4'b0011, 32'h1234_5678, 0, 0, 32'h0, RESP_OKAY,
                 2, 0, 1, RESP_OKAY, 32'hDEAD_BEEF, RESP_OKAY, 4};
      tbl[2] = '{1'b0, 32'h0000_0008, 4'h0, 32'h0, 0, 1, 32'hCAFE_0001, RESP_SLVERR,
                 0, 0, 0, RESP_OKAY, 32'hCAFE_0001, RESP_SLVERR, 2};
      tbl[3] = '{1'b0, 32'h0000_000C, 4'h0, 32'h0, 0, 1, 32'h0BAD_F00D, RESP_OKAY,
                 0, 0, 0, RESP_OKAY, 32'h0BAD_F00D, RESP_OKAY, 2};
      tbl[4] = '{1'b0, 32'h0000_0103, 4'h0, 32'h0, 1, 2, 32'h5555_AAAA, RESP_OKAY,
                 0, 0, 0, RESP_OKAY, 32'h5555_AAAA, RESP_OKAY, 4};
      tbl[5] = '{1'b1, 32'h0000_0020, 4'hF, 32'hA5A5_5A5A, 0, 0, 32'h0, RESP_OKAY,
                 0, 3, 2, RESP_SLVERR, 32'h5555_AAAA, RESP_SLVERR, 6};
      tbl[6] = '{1'b1, 32'h0000_0033, 4'b1100, 32'h0F0F_F0F0, 0, 0, 32'h0, RESP_OKAY,
                 0, 0, 1, RESP_OKAY, 32'h5555_AAAA, RESP_OKAY, 2};
      tbl[7] = '{1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0, 0, 1, 32'h1357_9BDF, RESP_DECERR,
                 0, 0, 0, RESP_OKAY, 32'h1357_9BDF, RESP_DECERR, 2};

      // Reset with a read request held on cs: nothing may be issued.
      bid = '0; rid = '0; rlast = 1'b1;
      fabric_idle();
      cs = 1'b1; we = 1'b0; addr = 32'h0000_0040; byte_en = 4'h0; di = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("reset arvalid", arvalid, 1'b0);
      check("reset awvalid", awvalid, 1'b0);
      check("reset wvalid", wvalid, 1'b0);
      check("reset bready", bready, 1'b0);
      check("reset rready", rready, 1'b0);
      check("reset busy", busy, 1'b0);
      check("reset do", dout, 32'h0);
      check("reset bad", bad, 2'b00);
      check("reset wr_err", wr_err, 1'b0);
      rst = 1'b0; cs = 1'b0;
      @(posedge clk); #1;
      check("idle after reset busy", busy, 1'b0);

      for (int i = 0; i < 8; i++) run_txn($sformatf("row%0d", i), tbl[i]);

      // Reset while waiting for read data.
      cs = 1'b1; we = 1'b0; addr = 32'h0000_0080;
      @(posedge clk); #1;
      cs = 1'b0;
      check("rd_d arvalid", arvalid, 1'b1);
      arready = 1'b1;
      @(posedge clk); #1;
      arready = 1'b0;
      check("rd_d rready", rready, 1'b1);
      check("rd_d busy", busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("mid-reset rready", rready, 1'b0);
      check("mid-reset busy", busy, 1'b0);
      check("mid-reset do", dout, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rv = '{1'b0, 32'h0000_0084, 4'h0, 32'h0, 0, 1, 32'h600D_CAFE, RESP_OKAY,
             0, 0, 0, RESP_OKAY, 32'h600D_CAFE, RESP_OKAY, 2};
      run_txn("post-reset read", rv);

`ifdef MEM2AXI_WPOST_EN
      begin
         int  pulses = 0;
         int  c = 3;
         bit  b_hs = 0, early_ar = 0, r_hs = 0, done = 0;
         cs = 1'b1; we = 1'b1; addr = 32'h0000_0200; byte_en = 4'hF; di = 32'h1111_2222;
         @(posedge clk); #1;
         cs = 1'b0;
         awready = 1'b1; wready = 1'b1;
         @(posedge clk); #1;
         fabric_idle();
         check("posted write busy", busy, 1'b0);
         check("posted write bad", bad, 2'b00);
         cs = 1'b1; we = 1'b0; addr = 32'h0000_0204;
         @(posedge clk); #1;
         cs = 1'b0;
         while (!done && c <= 40) begin
            fabric_idle();
            if (wr_err) pulses++;
            if (!b_hs && arvalid) early_ar = 1;
            if (r_hs && !busy) begin
               done = 1;
            end else begin
               if (c >= 6 && !b_hs) begin
                  bvalid = 1'b1; bresp = RESP_DECERR;
                  if (bready) b_hs = 1;
               end
               if (arvalid) arready = 1'b1;
               if (rready && !r_hs) begin
                  rvalid = 1'b1; rdata = 32'h7777_8888; rresp = RESP_OKAY; r_hs = 1;
               end
               @(posedge clk); #1;
               c++;
            end
         end
         fabric_idle();
         check("posted seq completed", done, 1'b1);
         check("posted arvalid before B", early_ar, 1'b0);
         check("posted wr_err pulses", pulses, 1);
         check("posted read do", dout, 32'h7777_8888);
         check("posted read bad", bad, 2'b00);
         check("posted bready idle", bready, 1'b0);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
